// File: rtl/controller_link_responder.sv
// Console-side responder for the serial controller link: receives button frames,
// returns a feedback frame on the same ControllerClk bursts, and tracks link liveness.
module controller_link_responder #(
  parameter int unsigned FRAME_BITS        = 32,
  parameter int unsigned TIMEOUT_CYCLES    = 1024,
  parameter int unsigned DISCONNECT_CYCLES = 1048576
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ControllerClk,
  input  logic                  ControllerIn,
  output logic                  ControllerOut,
  input  logic [FRAME_BITS-1:0] FeedbackData,
  input  logic                  FeedbackValid,
  output logic                  FeedbackReady,
  output logic [FRAME_BITS-1:0] ButtonData,
  output logic                  ButtonValid,
  output logic                  FrameError,
  output logic                  ControllerConnected
);

  localparam int unsigned RX_W  = FRAME_BITS + 1;
  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned DC_W  = $clog2(DISCONNECT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cclk_sync_q, cclk_sync_d;
  logic [1:0]            cin_sync_q, cin_sync_d;
  logic [FRAME_BITS-1:0] hold_q, hold_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [RX_W-1:0]       rx_q, rx_d;
  logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]      txcnt_q, txcnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [DC_W-1:0]       dc_q, dc_d;
  logic [FRAME_BITS-1:0] bdata_q, bdata_d;
  logic                  out_q, out_d;
  logic                  ready_q, ready_d;
  logic                  bvalid_q, bvalid_d;
  logic                  ferr_q, ferr_d;
  logic                  conn_q, conn_d;
  logic                  rise_c, fall_c, cin_c;

  // Synchronisers: s1 = bit 0, s2 = bit 1, s3 = bit 2 (edge-detect stage).
  always_comb begin
    cclk_sync_d = {cclk_sync_q[1:0], ControllerClk};
    cin_sync_d  = {cin_sync_q[0], ControllerIn};
    rise_c      = cclk_sync_q[1] & ~cclk_sync_q[2];
    fall_c      = ~cclk_sync_q[1] & cclk_sync_q[2];
    cin_c       = cin_sync_q[1];
  end

  always_ff @(posedge Clk) begin
    cclk_sync_q <= cclk_sync_d;
    cin_sync_q  <= cin_sync_d;
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    bitcnt_d = bitcnt_q;
    txcnt_d  = txcnt_q;
    tmo_d    = tmo_q;
    bdata_d  = bdata_q;
    bvalid_d = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_d   = '0;
        txcnt_d = '0;
        if (FeedbackValid && ready_q) begin
          hold_d = FeedbackData;
          tx_d   = FeedbackData;
        end
        if (rise_c) begin
          rx_d     = RX_W'(cin_c);
          bitcnt_d = CNT_W'(1);
          state_d  = RECV;
        end
      end
      RECV: begin
        if (fall_c && (txcnt_q != CNT_W'(FRAME_BITS))) begin
          tx_d    = tx_q << 1;
          txcnt_d = txcnt_q + CNT_W'(1);
        end
        if (rise_c) begin
          rx_d     = {rx_q[RX_W-2:0], cin_c};
          bitcnt_d = bitcnt_q + CNT_W'(1);
          tmo_d    = '0;
          if (bitcnt_q == CNT_W'(FRAME_BITS)) begin
            state_d = DONE;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          // Stalled link: abandon the frame and re-arm the feedback word.
          ferr_d  = 1'b1;
          rx_d    = '0;
          tx_d    = hold_q;
          txcnt_d = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DONE: begin
        if (!(^rx_q)) begin
          bdata_d  = rx_q[RX_W-1:1];
          bvalid_d = 1'b1;
        end else begin
          ferr_d = 1'b1;
        end
        tx_d    = hold_q;
        txcnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    // After all data bits have gone out, the parity of the held word follows.
    out_d = ((state_d == RECV) && (txcnt_d == CNT_W'(FRAME_BITS))) ? ^hold_d
                                                                    : tx_d[FRAME_BITS-1];

    if (bvalid_d) begin
      dc_d = '0;
    end else if (dc_q == DC_W'(DISCONNECT_CYCLES)) begin
      dc_d = dc_q;
    end else begin
      dc_d = dc_q + DC_W'(1);
    end

    if (bvalid_d) begin
      conn_d = 1'b1;
    end else if (dc_d == DC_W'(DISCONNECT_CYCLES)) begin
      conn_d = 1'b0;
    end else begin
      conn_d = conn_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      bitcnt_q <= '0;
      txcnt_q  <= '0;
      tmo_q    <= '0;
      dc_q     <= '0;
      bdata_q  <= '0;
      out_q    <= 1'b0;
      ready_q  <= 1'b0;
      bvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      conn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      bitcnt_q <= bitcnt_d;
      txcnt_q  <= txcnt_d;
      tmo_q    <= tmo_d;
      dc_q     <= dc_d;
      bdata_q  <= bdata_d;
      out_q    <= out_d;
      ready_q  <= ready_d;
      bvalid_q <= bvalid_d;
      ferr_q   <= ferr_d;
      conn_q   <= conn_d;
    end
  end

  assign ControllerOut       = out_q;
  assign FeedbackReady       = ready_q;
  assign ButtonData          = bdata_q;
  assign ButtonValid         = bvalid_q;
  assign FrameError          = ferr_q;
  assign ControllerConnected = conn_q;

endmodule

// File: tb/tb_controller_link_responder.sv
// Bench for controller_link_responder: plays the controller microcontroller and
// checks received frames, returned feedback bits, timeouts, reset and disconnect.
module tb_controller_link_responder;

  localparam int unsigned FB   = 32;
  localparam int unsigned TMO  = 1024;
  localparam int unsigned DISC = 4096;
  localparam int unsigned HALF = 8;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          ControllerClk = 1'b0;
  logic          ControllerIn = 1'b0;
  logic          ControllerOut;
  logic [FB-1:0] FeedbackData = '0;
  logic          FeedbackValid = 1'b0;
  logic          FeedbackReady;
  logic [FB-1:0] ButtonData;
  logic          ButtonValid;
  logic          FrameError;
  logic          ControllerConnected;

  controller_link_responder #(
    .FRAME_BITS(FB), .TIMEOUT_CYCLES(TMO), .DISCONNECT_CYCLES(DISC)
  ) dut (
    .Clk(Clk), .Reset(Reset), .ControllerClk(ControllerClk), .ControllerIn(ControllerIn),
    .ControllerOut(ControllerOut), .FeedbackData(FeedbackData), .FeedbackValid(FeedbackValid),
    .FeedbackReady(FeedbackReady), .ButtonData(ButtonData), .ButtonValid(ButtonValid),
    .FrameError(FrameError), .ControllerConnected(ControllerConnected)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int bv_cnt = 0, fe_cnt = 0, both_cnt = 0, wide_cnt = 0, drop_cnt = 0;
  int bv_cyc = 0, fe_cyc = 0, drop_cyc = 0;
  logic prev_bv = 1'b0, prev_fe = 1'b0, prev_conn = 1'b0;
  logic [FB-1:0] exp_bdata = '0;
  logic [FB-1:0] exp_hold = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Pulse bookkeeping, sampled half a cycle after each active edge.
  always @(negedge Clk) begin
    if (ButtonValid === 1'b1) begin bv_cnt++; bv_cyc = cyc; end
    if (FrameError === 1'b1) begin fe_cnt++; fe_cyc = cyc; end
    if (ButtonValid === 1'b1 && FrameError === 1'b1) both_cnt++;
    if ((ButtonValid === 1'b1 && prev_bv === 1'b1) || (FrameError === 1'b1 && prev_fe === 1'b1))
      wide_cnt++;
    if (prev_conn === 1'b1 && ControllerConnected === 1'b0 && Reset === 1'b0) begin
      drop_cnt++; drop_cyc = cyc;
    end
    prev_bv   = ButtonValid;
    prev_fe   = FrameError;
    prev_conn = ControllerConnected;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Microcontroller side: data set in the low phase, ControllerOut sampled at its rise.
  task automatic send_bits(input logic [FB-1:0] data, input logic par, input int nbits,
                           output logic [FB:0] obits);
    obits = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge Clk);
      ControllerIn = (i < int'(FB)) ? data[int'(FB) - 1 - i] : par;
      repeat (HALF) @(negedge Clk);
      obits = {obits[FB-1:0], ControllerOut};
      ControllerClk = 1'b1;
      rise_cyc = cyc;
      repeat (HALF) @(negedge Clk);
      ControllerClk = 1'b0;
    end
  endtask

  task automatic offer_fb(input logic [FB-1:0] w);
    @(negedge Clk);
    chk("fb_ready", 64'(FeedbackReady), 64'(1));
    FeedbackData  = w;
    FeedbackValid = 1'b1;
    @(negedge Clk);
    FeedbackValid = 1'b0;
    exp_hold = w;
  endtask

  task automatic do_frame(input logic [FB-1:0] data, input logic par);
    logic [FB:0] ob;
    int bv0, fe0;
    logic good;
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    send_bits(data, par, int'(FB) + 1, ob);
    repeat (12) @(negedge Clk);
    good = (par == ^data);
    if (good) exp_bdata = data;
    chk("bvalid_count", 64'(bv_cnt - bv0), good ? 64'(1) : 64'(0));
    chk("ferr_count", 64'(fe_cnt - fe0), good ? 64'(0) : 64'(1));
    chk("button_data", 64'(ButtonData), 64'(exp_bdata));
    chk("tx_bits", 64'(ob), 64'({exp_hold, ^exp_hold}));
    if (good) begin
      // Pin rise -> 3 synchroniser edges to detect, then DONE, then the pulse.
      chk("bvalid_latency", 64'(bv_cyc - rise_cyc), 64'(4));
      chk("connected", 64'(ControllerConnected), 64'(1));
    end
  endtask

  initial begin
    logic [FB:0] ob;
    logic [FB-1:0] d;
    int bv0, fe0, dc0;

    repeat (3) @(negedge Clk);
    chk("reset_outputs", 64'({ControllerOut, FeedbackReady, ButtonValid, FrameError,
                              ControllerConnected, ButtonData}), 64'(0));
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    chk("ready_idle", 64'(FeedbackReady), 64'(1));
    chk("not_connected", 64'(ControllerConnected), 64'(0));

    do_frame(32'hA5A50F0F, 1'b0);
    do_frame(32'hA5A50F0F, 1'b1);

    offer_fb(32'h0000_0001);
    do_frame($urandom(), 1'b0 ^ 1'b0 ^ 1'b0);
    d = $urandom();
    do_frame(d, ^d);

    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) offer_fb($urandom());
      d = $urandom();
      do_frame(d, ($urandom_range(0, 3) == 0) ? ~(^d) : ^d);
    end

    // Link stalls after 10 rises.
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    send_bits($urandom(), 1'b0, 10, ob);
    for (int w = 0; w < 2000 && fe_cnt == fe0; w++) @(negedge Clk);
    @(negedge Clk);
    chk("tmo_ferr", 64'(fe_cnt - fe0), 64'(1));
    chk("tmo_latency", 64'(fe_cyc - rise_cyc), 64'(3 + TMO));
    chk("tmo_ready", 64'(FeedbackReady), 64'(1));
    chk("tmo_no_bvalid", 64'(bv_cnt - bv0), 64'(0));
    d = $urandom();
    do_frame(d, ^d);

    // Reset partway through a frame.
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    send_bits($urandom(), 1'b0, 16, ob);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("midreset_outputs", 64'({ControllerOut, FeedbackReady, ButtonValid, FrameError,
                                 ControllerConnected, ButtonData}), 64'(0));
    Reset = 1'b0;
    exp_bdata = '0;
    exp_hold  = '0;
    repeat (20) @(negedge Clk);
    chk("midreset_no_pulse", 64'({32'(bv_cnt - bv0), 32'(fe_cnt - fe0)}), 64'(0));
    d = $urandom();
    do_frame(d, ^d);

    // Silence after a good frame.
    dc0 = drop_cnt;
    for (int w = 0; w < 6000 && drop_cnt == dc0; w++) @(negedge Clk);
    @(negedge Clk);
    chk("disc_drop", 64'(drop_cnt - dc0), 64'(1));
    chk("disc_latency", 64'(drop_cyc - bv_cyc), 64'(DISC));
    chk("disc_level", 64'(ControllerConnected), 64'(0));

    chk("pulse_overlap", 64'(both_cnt), 64'(0));
    chk("pulse_width", 64'(wide_cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
